// File: rtl/snitch_mem_loader_pkg.sv
// Shared types and helpers for the burst reqrsp memory loader.
// Default reqrsp channel types cover the 32-bit configuration.
package snitch_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Byte distance between consecutive words of a burst.
    function automatic int unsigned addr_incr(int unsigned data_width);
        return data_width / 8;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } default_req_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        error;
    } default_rsp_chan_t;

    typedef struct packed {
        default_req_chan_t q;
        logic              q_valid;
        logic              p_ready;
    } default_dreq_t;

    typedef struct packed {
        default_rsp_chan_t p;
        logic              p_valid;
        logic              q_ready;
    } default_drsp_t;

endpackage

// File: rtl/snitch_mem_loader.sv
// Burst reqrsp initiator: turns one host burst command into single-word
// requests with a bounded number in flight; responses return in order.
//
// state | meaning
// IDLE  | accept a command; zero-length commands complete here; strays dropped
// ISSUE | issue requests while words remain and there is room in flight
// DRAIN | all requests issued, wait for the remaining responses
module snitch_mem_loader
    import snitch_mem_loader_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned LenWidth       = 16,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         dreq_t         = default_dreq_t,
    parameter type         drsp_t         = default_drsp_t,
    localparam int unsigned StrbWidth     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [StrbWidth-1:0] wstrb_i,
    output logic                 rdata_valid_o,
    input  logic                 rdata_ready_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output dreq_t                data_req_o,
    input  drsp_t                data_rsp_i
);

    localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
    localparam logic [OutWidth-1:0] MaxOut = OutWidth'(MaxOutstanding);
    localparam logic [AddrWidth-1:0] AddrStep = AddrWidth'(addr_incr(DataWidth));
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

    state_e               state, state_next;
    logic                 write_q;
    logic [AddrWidth-1:0] addr_q;
    logic [LenWidth-1:0]  remaining_q;
    logic [OutWidth-1:0]  outstanding_q, outstanding_next;
    logic                 err_q, done_q, error_q;
    logic                 room, q_valid, p_ready;
    logic                 cmd_fire, q_fire, p_fire, drain_exit;

    assign room       = (remaining_q != '0) && (outstanding_q < MaxOut);
    assign cmd_fire   = cmd_valid_i && (state == IDLE);
    assign q_fire     = q_valid && data_rsp_i.q_ready;
    // Responses outside a burst are strays and never touch the counter.
    assign p_fire     = p_ready && data_rsp_i.p_valid && (state != IDLE) && (outstanding_q != '0);
    assign drain_exit = (state == DRAIN) && (outstanding_next == '0);

    always_comb begin
        outstanding_next = outstanding_q;
        if (q_fire && !p_fire) begin
            outstanding_next = outstanding_q + OutWidth'(1);
        end else if (!q_fire && p_fire) begin
            outstanding_next = outstanding_q - OutWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire && (cmd_len_i != '0)) state_next = ISSUE;
            ISSUE:   if (q_fire && (remaining_q == LenWidth'(1))) state_next = DRAIN;
            DRAIN:   if (drain_exit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        q_valid       = 1'b0;
        p_ready       = 1'b1;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        case (state)
            ISSUE: begin
                if (write_q) begin
                    q_valid       = room && wdata_valid_i;
                    wdata_ready_o = room && data_rsp_i.q_ready;
                end else begin
                    q_valid       = room;
                    p_ready       = rdata_ready_i;
                    rdata_valid_o = data_rsp_i.p_valid;
                end
            end
            DRAIN: begin
                if (!write_q) begin
                    p_ready       = rdata_ready_i;
                    rdata_valid_o = data_rsp_i.p_valid;
                end
            end
            default: ;
        endcase
        data_req_o         = '0;
        data_req_o.q.addr  = addr_q;
        data_req_o.q.write = write_q;
        data_req_o.q.data  = write_q ? wdata_i : '0;
        data_req_o.q.strb  = write_q ? wstrb_i : '1;
        data_req_o.q_valid = q_valid;
        data_req_o.p_ready = p_ready;
        rdata_o            = data_rsp_i.p.data;
        cmd_ready_o        = (state == IDLE);
        busy_o             = (state != IDLE);
        done_o             = done_q;
        error_o            = error_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q       <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            outstanding_q <= outstanding_next;
            if (cmd_fire) begin
                write_q     <= cmd_write_i;
                addr_q      <= cmd_addr_i & AlignMask;
                remaining_q <= cmd_len_i;
                err_q       <= 1'b0;
                done_q      <= (cmd_len_i == '0);
            end
            if (q_fire) begin
                addr_q      <= addr_q + AddrStep;
                remaining_q <= remaining_q - LenWidth'(1);
            end
            if (p_fire && data_rsp_i.p.error) begin
                err_q <= 1'b1;
            end
            // The final response's error bit is folded in the same cycle it arrives.
            if (drain_exit) begin
                done_q  <= 1'b1;
                error_q <= err_q || (p_fire && data_rsp_i.p.error);
            end
        end
    end

endmodule

// File: tb/tb_snitch_mem_loader.sv
// Bench for snitch_mem_loader: randomized responder/streams against a
// transaction-level model of the burst, request and completion rules.
module tb_snitch_mem_loader;
    import snitch_mem_loader_pkg::*;

    localparam int MaxOut = 2;

    typedef struct {logic [31:0] addr; logic write; logic [31:0] data; logic [3:0] strb;} req_t;
    typedef struct {logic [31:0] data; logic err; int due;} rsp_t;
    typedef struct {logic [31:0] data; logic [3:0] strb;} wbeat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [15:0]   cmd_len = '0;
    logic          wdata_valid = 1'b0, wdata_ready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          rdata_valid, rdata_ready = 1'b0;
    logic [31:0]   rdata;
    logic          busy, done, error;
    default_dreq_t data_req;
    default_drsp_t data_rsp = '0;

    snitch_mem_loader #(
        .AddrWidth(32), .DataWidth(32), .LenWidth(16), .MaxOutstanding(MaxOut),
        .dreq_t(default_dreq_t), .drsp_t(default_drsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata), .wstrb_i(wstrb),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .busy_o(busy), .done_o(done), .error_o(error),
        .data_req_o(data_req), .data_rsp_i(data_rsp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Environment knobs and shared state
    int lat_min = 1, lat_max = 1, qready_pct = 100, wvalid_pct = 100, rready_mode = 2;
    bit err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int cyc = 0;
    logic [31:0] sram [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    rsp_t pend[$];
    req_t exp_req[$];
    logic [31:0] exp_rd[$];
    wbeat_t wq[$];

    // Model of the burst as seen from the ports
    bit m_busy = 0, m_write = 0, m_done = 0, m_err = 0, m_err_out = 0;
    int m_out = 0, m_rem = 0;

    function automatic logic [31:0] bg(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        return sram.exists(a) ? sram[a] : bg(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    always begin : cycle_proc
        logic q_fire, p_fire, counted, room, exp_pready, cmd_fire, prev_stall;
        logic [31:0] prev_addr, e_rd, wv, a;
        req_t r;
        bit rr_toggle;
        @(negedge clk);
        cyc++;
        // Responder and stream drivers
        data_rsp.q_ready = (int'($urandom_range(0, 99)) < qready_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            data_rsp.p_valid = 1'b1;
            data_rsp.p.data  = pend[0].data;
            data_rsp.p.error = pend[0].err;
        end else begin
            data_rsp.p_valid = 1'b0;
            data_rsp.p.data  = $urandom;
            data_rsp.p.error = 1'b0;
        end
        if (wq.size() > 0 && int'($urandom_range(0, 99)) < wvalid_pct) begin
            wdata_valid = 1'b1;
            wdata = wq[0].data;
            wstrb = wq[0].strb;
        end else begin
            wdata_valid = 1'b0;
        end
        rr_toggle = ~rr_toggle;
        case (rready_mode)
            0:       rdata_ready = (int'($urandom_range(0, 99)) < 60);
            1:       rdata_ready = rr_toggle;
            default: rdata_ready = 1'b1;
        endcase
        #1;
        q_fire = data_req.q_valid && data_rsp.q_ready;
        p_fire = data_rsp.p_valid && data_req.p_ready;
        if (rst) begin
            m_busy = 0; m_done = 0; m_out = 0; m_rem = 0; m_err = 0;
            exp_req.delete(); exp_rd.delete(); wq.delete();
            prev_stall = 1'b0;
        end else begin
            room = m_busy && m_rem > 0 && m_out < MaxOut;
            cmd_fire = cmd_valid && !m_busy;
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("error", 64'(error), 64'(m_done && m_err_out));
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy));
            if (m_busy && m_write) begin
                chk("q_valid_wr", 64'(data_req.q_valid), 64'(room && wdata_valid));
                chk("wdata_ready", 64'(wdata_ready), 64'(room && data_rsp.q_ready));
                chk("rdata_valid_wr", 64'(rdata_valid), 64'd0);
                exp_pready = 1'b1;
            end else if (m_busy) begin
                chk("q_valid_rd", 64'(data_req.q_valid), 64'(room));
                chk("wdata_ready_rd", 64'(wdata_ready), 64'd0);
                chk("rdata_valid", 64'(rdata_valid), 64'(data_rsp.p_valid));
                if (data_rsp.p_valid) chk("rdata_pass", 64'(rdata), 64'(data_rsp.p.data));
                if (prev_stall && data_req.q_valid) chk("q_stable", 64'(data_req.q.addr), 64'(prev_addr));
                exp_pready = rdata_ready;
            end else begin
                chk("q_valid_idle", 64'(data_req.q_valid), 64'd0);
                chk("wdata_ready_idle", 64'(wdata_ready), 64'd0);
                chk("rdata_valid_idle", 64'(rdata_valid), 64'd0);
                exp_pready = 1'b1;
            end
            chk("p_ready", 64'(data_req.p_ready), 64'(exp_pready));
            prev_stall = m_busy && !m_write && data_req.q_valid && !data_rsp.q_ready;
            prev_addr  = data_req.q.addr;
            counted = p_fire && m_busy && m_out > 0;
            if (q_fire && m_busy) begin
                r = '{32'hx, 1'bx, 32'hx, 4'hx};
                if (exp_req.size() > 0) r = exp_req.pop_front();
                chk("q_addr", 64'(data_req.q.addr), 64'(r.addr));
                chk("q_write", 64'(data_req.q.write), 64'(r.write));
                chk("q_strb", 64'(data_req.q.strb), 64'(r.strb));
                if (r.write) chk("q_data", 64'(data_req.q.data), 64'(r.data));
                if (m_rem > 0) m_rem--;
                m_out++;
            end
            if (counted) begin
                if (!m_write) begin
                    e_rd = 32'hx;
                    if (exp_rd.size() > 0) e_rd = exp_rd.pop_front();
                    chk("rdata", 64'(rdata), 64'(e_rd));
                end
                if (data_rsp.p.error) m_err = 1;
                m_out--;
            end
            m_done = 0;
            if (m_busy && m_rem == 0 && m_out == 0) begin
                m_done = 1; m_err_out = m_err; m_busy = 0;
            end
            if (cmd_fire) begin
                if (cmd_len == 16'd0) begin
                    m_done = 1; m_err_out = 0;
                end else begin
                    m_busy = 1; m_write = cmd_write; m_rem = int'(cmd_len); m_err = 0;
                end
            end
        end
        // Responder memory and response pipeline
        if (p_fire) void'(pend.pop_front());
        if (q_fire) begin
            a = data_req.q.addr;
            if (data_req.q.write) begin
                wv = sram_rd(a);
                for (int b = 0; b < 4; b++) if (data_req.q.strb[b]) wv[8*b +: 8] = data_req.q.data[8*b +: 8];
                sram[a] = wv;
                pend.push_back('{$urandom, err_en && a == err_addr, cyc + int'($urandom_range(lat_min, lat_max))});
            end else begin
                pend.push_back('{sram_rd(a), err_en && a == err_addr, cyc + int'($urandom_range(lat_min, lat_max))});
            end
        end
        if (wdata_valid && wdata_ready) void'(wq.pop_front());
    end

    task automatic prep(input bit wr, input logic [31:0] addr, input int len, input bit directed);
        logic [31:0] a, d, old;
        logic [3:0] s;
        a = addr & ~32'h3;
        for (int i = 0; i < len; i++) begin
            if (directed) begin d = 32'h11 * (i + 1); s = 4'hF; end
            else begin d = $urandom; s = 4'($urandom_range(0, 15)); end
            if (wr) begin
                wq.push_back('{d, s});
                old = ref_rd(a);
                for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
                ref_mem[a] = old;
                exp_req.push_back('{a, 1'b1, d, s});
            end else begin
                exp_req.push_back('{a, 1'b0, 32'h0, 4'hF});
                exp_rd.push_back(ref_rd(a));
            end
            a = a + 32'd4;
        end
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len);
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len, input bit directed,
                           output logic err_seen);
        bit seen;
        prep(wr, addr, len, directed);
        issue(wr, addr, len);
        seen = 0;
        err_seen = 1'bx;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_len = 16'($urandom);
            #2;
            if (done) begin seen = 1; err_seen = error; end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("reqs_left", 64'(exp_req.size()), 64'd0);
        chk("rdata_left", 64'(exp_rd.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_q_valid", 64'(data_req.q_valid), 64'd0);
        chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
        chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
    endtask

    initial begin : stim
        logic e;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk_reset_outputs();

        // Write 4 words, unaligned start, 1-cycle responder
        run_cmd(1'b1, 32'h8000_0003, 4, 1'b1, e);
        chk("wr4_error", 64'(e), 64'd0);
        chk("wr4_mem3", 64'(sram_rd(32'h8000_000C)), 64'h44);

        // Read back with rdata_ready toggling
        rready_mode = 1; lat_min = 1; lat_max = 3;
        run_cmd(1'b0, 32'h8000_0000, 3, 1'b0, e);
        chk("rd3_error", 64'(e), 64'd0);

        // Outstanding limit with slow responder, both directions
        rready_mode = 2; lat_min = 5; lat_max = 5;
        run_cmd(1'b0, 32'h8000_0000, 6, 1'b0, e);
        run_cmd(1'b1, 32'h8000_0100, 6, 1'b0, e);

        // Zero-length commands
        lat_min = 1; lat_max = 2;
        run_cmd(1'b1, 32'h1234_5678, 0, 1'b0, e);
        chk("len0_error", 64'(e), 64'd0);
        run_cmd(1'b0, 32'h1234_5678, 0, 1'b0, e);

        // Address wrap with an error on the second beat
        err_en = 1'b1; err_addr = 32'h0000_0000;
        run_cmd(1'b1, 32'hFFFF_FFFC, 2, 1'b0, e);
        chk("wrap_error", 64'(e), 64'd1);
        chk("wrap_mem0_written", 64'(sram.exists(32'h0)), 64'd1);
        err_en = 1'b0;
        run_cmd(1'b0, 32'hFFFF_FFFC, 2, 1'b0, e);
        chk("after_err_clean", 64'(e), 64'd0);

        // Randomized bursts in a shared window so reads observe earlier writes
        for (int k = 0; k < 14; k++) begin
            lat_min = int'($urandom_range(1, 2)); lat_max = lat_min + int'($urandom_range(0, 3));
            qready_pct = int'($urandom_range(50, 100)); wvalid_pct = int'($urandom_range(40, 100));
            rready_mode = int'($urandom_range(0, 2));
            run_cmd(1'($urandom), 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4, int'($urandom_range(0, 10)), 1'b0, e);
        end

        // Reset in the middle of an 8-word read
        qready_pct = 100; rready_mode = 2; lat_min = 3; lat_max = 3;
        prep(1'b0, 32'h1000_0000, 8, 1'b0);
        issue(1'b0, 32'h1000_0000, 8);
        n = 0;
        for (int i = 0; i < 50 && exp_req.size() > 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #2;
        end
        chk("two_issued", 64'(exp_req.size() <= 6), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_reset_outputs();
        for (int i = 0; i < 50 && pend.size() > 0; i++) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("strays_drained", 64'(pend.size()), 64'd0);
        run_cmd(1'b0, 32'h1000_0004, 1, 1'b0, e);
        chk("post_reset_error", 64'(e), 64'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
